// File: rtl/adder_tree_pkg.sv
// adder_tree_pkg: shared defaults, sideband beat type and elaboration-time helpers
// for the adder_tree_acc pipeline.
package adder_tree_pkg;
    localparam int DEF_WIDTH      = 8;
    localparam int DEF_NUM_INPUTS = 3;
    localparam int DEF_OUT_WIDTH  = 16;

    typedef struct packed {
        logic cin;
        logic acc_mode;
        logic acc_clear;
        logic valid;
    } sideband_t;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Operand count remaining after k pairwise tree levels.
    function automatic int level_cnt(input int n, input int k);
        return (n + (1 << k) - 1) >> k;
    endfunction
endpackage

// File: rtl/add_level.sv
// add_level: one registered binary adder-tree level; pairs are summed one bit wider,
// an odd leftover operand is zero-extended and passed through.
module add_level
    import adder_tree_pkg::*;
#(
    parameter int N_IN = 3,
    parameter int W    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_en,
    input  logic [N_IN*W-1:0]             i_d,
    input  sideband_t                     i_sb,
    output logic [((N_IN+1)/2)*(W+1)-1:0] o_d,
    output sideband_t                     o_sb
);
    localparam int N_OUT = (N_IN + 1) / 2;

    logic [N_OUT*(W+1)-1:0] w_sum;

    always_comb begin
        w_sum = '0;
        for (int j = 0; j < N_IN / 2; j++)
            w_sum[j*(W+1) +: W+1] = (W+1)'(i_d[2*j*W +: W]) + (W+1)'(i_d[(2*j+1)*W +: W]);
        if (N_IN % 2 == 1)
            w_sum[(N_OUT-1)*(W+1) +: W+1] = (W+1)'(i_d[(N_IN-1)*W +: W]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_d  <= '0;
            o_sb <= '0;
        end else if (i_en) begin
            o_d  <= w_sum;
            o_sb <= i_sb;
        end
    end
endmodule

// File: rtl/adder_tree_acc.sv
// adder_tree_acc: pipelined adder tree over NUM_INPUTS operands with carry-in,
// optional wrapping accumulator with sticky overflow, and valid/ready flow control.
module adder_tree_acc
    import adder_tree_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int NUM_INPUTS = DEF_NUM_INPUTS,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
    input  logic                        cin,
    input  logic                        acc_mode,
    input  logic                        acc_clear,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_WIDTH-1:0]        sum,
    output logic                        ovf
);
    localparam int LVLS = clog2(NUM_INPUTS);
    localparam int TW   = WIDTH + LVLS;

    if (NUM_INPUTS < 1 || NUM_INPUTS > 16) begin : g_bad_inputs
        $error("adder_tree_acc: NUM_INPUTS must be 1..16");
    end
    if (OUT_WIDTH < TW) begin : g_bad_width
        $error("adder_tree_acc: OUT_WIDTH too narrow for exact tree result");
    end

    logic                 w_stall;
    logic                 w_acc_add;
    logic                 w_carry;
    sideband_t            w_sb_in;
    sideband_t            w_sb_tree;
    logic [TW-1:0]        w_tree;
    logic [OUT_WIDTH-1:0] w_beat;
    logic [OUT_WIDTH-1:0] w_acc_sum;
    logic                 r_valid;
    logic                 r_ovf;
    logic                 r_sticky;
    logic [OUT_WIDTH-1:0] r_sum;
    logic [OUT_WIDTH-1:0] r_acc;

    assign w_stall  = r_valid && !out_ready;
    assign in_ready = !w_stall;
    assign w_sb_in  = '{cin: cin, acc_mode: acc_mode, acc_clear: acc_clear, valid: in_valid};

    for (genvar k = 0; k < LVLS; k++) begin : g_lvl
        localparam int NI = level_cnt(NUM_INPUTS, k);
        localparam int NO = level_cnt(NUM_INPUTS, k + 1);
        localparam int IW = WIDTH + k;
        logic [NI*IW-1:0]     w_d;
        logic [NO*(IW+1)-1:0] w_q;
        sideband_t            w_sbi;
        sideband_t            w_sbo;
        if (k == 0) begin : g_first
            assign w_d   = in_data;
            assign w_sbi = w_sb_in;
        end else begin : g_next
            assign w_d   = g_lvl[k-1].w_q;
            assign w_sbi = g_lvl[k-1].w_sbo;
        end
        add_level #(.N_IN(NI), .W(IW)) u_level (
            .clk (clk),
            .rst (rst),
            .i_en(!w_stall),
            .i_d (w_d),
            .i_sb(w_sbi),
            .o_d (w_q),
            .o_sb(w_sbo)
        );
    end

    if (LVLS == 0) begin : g_flat
        assign w_tree    = in_data;
        assign w_sb_tree = w_sb_in;
    end else begin : g_tree
        assign w_tree    = g_lvl[LVLS-1].w_q;
        assign w_sb_tree = g_lvl[LVLS-1].w_sbo;
    end

    // cin is folded in here so a single-operand tree still needs no adder level
    assign w_beat              = OUT_WIDTH'(w_tree) + OUT_WIDTH'(w_sb_tree.cin);
    assign {w_carry, w_acc_sum} = {1'b0, r_acc} + {1'b0, w_beat};
    assign w_acc_add           = w_sb_tree.acc_mode && !w_sb_tree.acc_clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_sum    <= '0;
            r_ovf    <= 1'b0;
            r_acc    <= '0;
            r_sticky <= 1'b0;
        end else if (!w_stall) begin
            r_valid <= w_sb_tree.valid;
            if (w_sb_tree.valid) begin
                r_sum <= w_acc_add ? w_acc_sum : w_beat;
                r_ovf <= w_acc_add && (r_sticky || w_carry);
                if (w_sb_tree.acc_mode) begin
                    r_acc    <= w_sb_tree.acc_clear ? w_beat : w_acc_sum;
                    r_sticky <= w_acc_add && (r_sticky || w_carry);
                end
            end
        end
    end

    assign out_valid = r_valid;
    assign sum       = r_sum;
    assign ovf       = r_ovf;
endmodule

// File: tb/tb_adder_tree_acc.sv
// tb_adder_tree_acc: directed tables, corner sequences and randomized backpressure
// runs against an integer-arithmetic model, over four parameterisations.
module tb_adder_tree_acc;
    logic clk = 1'b0, rst = 1'b1, cin = 1'b0, acc_mode = 1'b0, acc_clear = 1'b0, out_ready = 1'b1;

    logic m_iv = 1'b0, m_ir, m_ov, m_ovf;
    logic [23:0] m_data = '0;
    logic [15:0] m_sum;
    logic t_iv = 1'b0, t_ir, t_ov, t_ovf;
    logic [23:0] t_data = '0;
    logic [9:0]  t_sum;
    logic s_iv = 1'b0, s_ir, s_ov, s_ovf;
    logic [3:0]  s_data = '0;
    logic [15:0] s_sum;
    logic h_iv = 1'b0, h_ir, h_ov, h_ovf;
    logic [127:0] h_data = '0;
    logic [15:0] h_sum;

    logic        ov[4], ir[4], of[4];
    logic [15:0] sm[4];

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    adder_tree_acc dut_main (
        .clk(clk), .rst(rst), .in_valid(m_iv), .in_ready(m_ir), .in_data(m_data), .cin(cin),
        .acc_mode(acc_mode), .acc_clear(acc_clear), .out_valid(m_ov), .out_ready(out_ready),
        .sum(m_sum), .ovf(m_ovf));
    adder_tree_acc #(.OUT_WIDTH(10)) dut_w10 (
        .clk(clk), .rst(rst), .in_valid(t_iv), .in_ready(t_ir), .in_data(t_data), .cin(cin),
        .acc_mode(acc_mode), .acc_clear(acc_clear), .out_valid(t_ov), .out_ready(out_ready),
        .sum(t_sum), .ovf(t_ovf));
    adder_tree_acc #(.WIDTH(4), .NUM_INPUTS(1)) dut_n1 (
        .clk(clk), .rst(rst), .in_valid(s_iv), .in_ready(s_ir), .in_data(s_data), .cin(cin),
        .acc_mode(acc_mode), .acc_clear(acc_clear), .out_valid(s_ov), .out_ready(out_ready),
        .sum(s_sum), .ovf(s_ovf));
    adder_tree_acc #(.WIDTH(8), .NUM_INPUTS(16)) dut_n16 (
        .clk(clk), .rst(rst), .in_valid(h_iv), .in_ready(h_ir), .in_data(h_data), .cin(cin),
        .acc_mode(acc_mode), .acc_clear(acc_clear), .out_valid(h_ov), .out_ready(out_ready),
        .sum(h_sum), .ovf(h_ovf));

    assign ov[0] = m_ov;  assign ir[0] = m_ir;  assign of[0] = m_ovf;  assign sm[0] = m_sum;
    assign ov[1] = t_ov;  assign ir[1] = t_ir;  assign of[1] = t_ovf;  assign sm[1] = {6'b0, t_sum};
    assign ov[2] = s_ov;  assign ir[2] = s_ir;  assign of[2] = s_ovf;  assign sm[2] = s_sum;
    assign ov[3] = h_ov;  assign ir[3] = h_ir;  assign of[3] = h_ovf;  assign sm[3] = h_sum;

    typedef struct {
        logic [7:0] a, b, c;
        bit         ci, md, cl;
        int         es;
        bit         eo;
    } vec_t;
    vec_t tv[13];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int w, logic [23:0] d, logic v);
        if (w == 0) begin
            m_iv = v; m_data = d;
        end else begin
            t_iv = v; t_data = d;
        end
    endtask

    task automatic idle_all();
        m_iv = 1'b0; t_iv = 1'b0; s_iv = 1'b0; h_iv = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_all();
        step();
        step();
        rst = 1'b0;
    endtask

    // Counts edges from the transfer edge until out_valid; 0 means it never came.
    task automatic measure(int w, output int lat);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (n == 1) idle_all();
            if (ov[w]) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_table(int w, int first, int n);
        fork
            begin
                for (int i = first; i < first + n; i++) begin
                    cin = tv[i].ci; acc_mode = tv[i].md; acc_clear = tv[i].cl;
                    drive(w, {tv[i].c, tv[i].b, tv[i].a}, 1'b1);
                    step();
                end
                drive(w, '0, 1'b0);
            end
            begin
                int k = 0;
                while (!ov[w] && k < 20) begin
                    step();
                    k++;
                end
                chk("tbl_first_out", 64'(k < 20), 1);
                for (int i = first; i < first + n; i++) begin
                    chk($sformatf("tbl%0d_valid", i), ov[w], 1);
                    chk($sformatf("tbl%0d_sum", i), sm[w], tv[i].es);
                    chk($sformatf("tbl%0d_ovf", i), of[w], tv[i].eo);
                    step();
                end
            end
        join
    endtask

    task automatic rand_run(int w, int nb, int ow);
        longint acc = 0, beat, tot;
        longint mask = (longint'(1) << ow) - 1;
        bit st = 1'b0, c_out;
        longint q[$];
        longint e;
        int sent = 0, cyc = 0;
        bit was_stall = 1'b0, tin, tout;
        logic [15:0] held_s, ps;
        logic held_o, po;
        logic [7:0] a, b, c;
        while ((sent < nb || q.size() > 0) && cyc < 3000) begin
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
            cin = 1'($urandom_range(0, 1));
            acc_mode = 1'($urandom_range(0, 1));
            acc_clear = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            drive(w, {c, b, a}, sent < nb && $urandom_range(0, 3) != 0);
            #1;
            tin = (w == 0 ? m_iv : t_iv) && ir[w];
            tout = ov[w] && out_ready;
            ps = sm[w];
            po = of[w];
            chk("in_ready", ir[w], !(ov[w] && !out_ready));
            if (was_stall) begin
                chk("stall_valid", ov[w], 1);
                chk("stall_sum", ps, held_s);
                chk("stall_ovf", po, held_o);
            end
            was_stall = ov[w] && !out_ready;
            held_s = ps;
            held_o = po;
            @(posedge clk);
            #1;
            cyc++;
            if (tout) begin
                chk("out_pending", 64'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("rand_sum", ps, e & 'hffff);
                    chk("rand_ovf", po, e >> 16);
                end
            end
            if (tin) begin
                beat = longint'(a) + longint'(b) + longint'(c) + longint'(cin);
                if (!acc_mode) begin
                    e = beat & mask;
                end else if (acc_clear) begin
                    acc = beat & mask;
                    st = 1'b0;
                    e = acc;
                end else begin
                    tot = acc + beat;
                    c_out = tot > mask;
                    acc = tot & mask;
                    st = st | c_out;
                    e = acc | (longint'(st) << 16);
                end
                q.push_back(e);
                sent++;
            end
        end
        drive(w, '0, 1'b0);
        out_ready = 1'b1;
        chk("rand_sent", sent, nb);
        chk("rand_drained", q.size(), 0);
    endtask

    initial begin
        int lat;
        bit stale;
        tv[0]  = '{8'd4,   8'd5,   8'd11,  1'b0, 1'b0, 1'b0, 20,  1'b0};
        tv[1]  = '{8'd15,  8'd3,   8'd200, 1'b1, 1'b0, 1'b0, 219, 1'b0};
        tv[2]  = '{8'd255, 8'd255, 8'd255, 1'b1, 1'b0, 1'b0, 766, 1'b0};
        tv[3]  = '{8'd1,   8'd2,   8'd3,   1'b0, 1'b1, 1'b1, 6,   1'b0};
        tv[4]  = '{8'd10,  8'd10,  8'd10,  1'b0, 1'b1, 1'b0, 36,  1'b0};
        tv[5]  = '{8'd100, 8'd0,   8'd0,   1'b0, 1'b1, 1'b0, 136, 1'b0};
        tv[6]  = '{8'd7,   8'd0,   8'd0,   1'b0, 1'b0, 1'b0, 7,   1'b0};
        tv[7]  = '{8'd0,   8'd0,   8'd0,   1'b1, 1'b1, 1'b0, 137, 1'b0};
        tv[8]  = '{8'd255, 8'd255, 8'd255, 1'b0, 1'b1, 1'b1, 765, 1'b0};
        tv[9]  = '{8'd255, 8'd255, 8'd255, 1'b0, 1'b1, 1'b0, 506, 1'b1};
        tv[10] = '{8'd1,   8'd1,   8'd1,   1'b0, 1'b0, 1'b0, 3,   1'b0};
        tv[11] = '{8'd0,   8'd0,   8'd0,   1'b0, 1'b1, 1'b0, 506, 1'b1};
        tv[12] = '{8'd0,   8'd0,   8'd0,   1'b1, 1'b1, 1'b1, 1,   1'b0};

        do_reset();
        chk("rst_out_valid", m_ov, 0);
        chk("rst_sum", m_sum, 0);
        chk("rst_ovf", m_ovf, 0);
        chk("rst_in_ready", m_ir, 1);

        cin = 1'b0; acc_mode = 1'b0; acc_clear = 1'b0;
        drive(0, {8'd11, 8'd5, 8'd4}, 1'b1);
        measure(0, lat);
        chk("lat_default", lat, 3);
        chk("lat_sum", m_sum, 20);
        chk("lat_ovf", m_ovf, 0);
        step();

        run_table(0, 0, 8);
        run_table(1, 8, 5);

        // Reset with two accumulate beats still inside the tree.
        do_reset();
        acc_mode = 1'b1; acc_clear = 1'b1; cin = 1'b0;
        drive(0, {8'd1, 8'd1, 8'd1}, 1'b1);
        measure(0, lat);
        chk("pre_rst_sum", m_sum, 3);
        acc_clear = 1'b0;
        drive(0, {8'd5, 8'd5, 8'd5}, 1'b1);
        step();
        drive(0, {8'd6, 8'd6, 8'd6}, 1'b1);
        step();
        drive(0, '0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_out_valid", m_ov, 0);
        chk("midrst_sum", m_sum, 0);
        chk("midrst_in_ready", m_ir, 1);
        stale = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            stale |= m_ov;
        end
        chk("midrst_no_stale", stale, 0);
        drive(0, {8'd3, 8'd2, 8'd1}, 1'b1);
        measure(0, lat);
        chk("midrst_lat", lat, 3);
        chk("midrst_acc_restart", m_sum, 6);
        chk("midrst_ovf", m_ovf, 0);

        do_reset();
        rand_run(0, 40, 16);
        do_reset();
        rand_run(1, 40, 10);

        do_reset();
        cin = 1'b1; acc_mode = 1'b0; acc_clear = 1'b0;
        s_data = 4'hF; s_iv = 1'b1;
        measure(2, lat);
        chk("n1_lat", lat, 1);
        chk("n1_sum", s_sum, 16);
        step();
        h_data = '1; h_iv = 1'b1;
        measure(3, lat);
        chk("n16_lat", lat, 5);
        chk("n16_sum", h_sum, 4081);
        chk("n16_ovf", h_ovf, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
